// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, default parameters and sizing helper
// for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    // Bits needed to index n values, never less than one.
    function automatic int bits_for(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with synchronous write and combinational read;
// contents are deliberately not reset.
module mem_array #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request/response memory slave with
// programmable wait states, alignment/range checking and registered response.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int CW = bits_for(WAIT_CYCLES + 1);
    localparam int AW = bits_for(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              cur_write, cur_err, accept, go_resp, mem_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata, mem_rdata;

    assign req_ready = reset && state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the latches hold the request, so IDLE uses the live bus.
    assign cur_write = state == IDLE ? req_write : lat_write;
    assign cur_addr  = state == IDLE ? req_addr  : lat_addr;
    assign cur_wdata = state == IDLE ? req_wdata : lat_wdata;
    assign cur_err   = cur_addr[0] || {1'b0, cur_addr[ADDR_W-1:1]} >= DEPTH_L;
    assign go_resp   = state == IDLE ? accept && WAIT_CYCLES == 0
                                     : state == WAIT && cnt == CW'(1);
    assign mem_we    = go_resp && cur_write && !cur_err;

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_addr[AW:1]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = WAIT_CYCLES == 0 ? RESP : WAIT;
            WAIT:    if (cnt == CW'(1)) next = RESP;
            RESP:    if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CW'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (!cur_write && !cur_err) ? mem_rdata : '0;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, storage, error handling,
// backpressure, reset abort and zero-wait back-to-back operation.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] req_addr, req_wdata, rsp_rdata;
    logic        z_req_valid, z_req_write, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [15:0] z_req_addr, z_req_wdata, z_rsp_rdata;

    int          compared = 0;
    int          mismatched = 0;
    int          lat;
    logic [15:0] rd;
    logic        er;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_zero (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ready(z_req_ready),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .busy(z_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output int l, output logic [15:0] r, output logic e);
        l = 1;
        while (!rsp_valid && l < 20) begin
            tick();
            l++;
        end
        r = rsp_rdata;
        e = rsp_err;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_clr_valid"}, rsp_valid, 0);
        chk({tag, "_clr_rdata"}, rsp_rdata, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err);
        send(w, a, d);
        get_rsp(lat, rd, er);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, er, exp_err);
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {req_valid, req_write, req_addr, req_wdata, rsp_ready} = '0;
        {z_req_valid, z_req_write, z_req_addr, z_req_wdata, z_rsp_ready} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_z_req_ready", z_req_ready, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        tick();

        txn("wr_0000", 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0);
        txn("wr_0010", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        txn("rd_0010", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        txn("wr_0200", 1'b1, 16'h0200, 16'h5555, 16'h0000, 1'b1);
        txn("rd_0000", 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0);
        txn("wr_0011", 1'b1, 16'h0011, 16'h7777, 16'h0000, 1'b1);
        txn("rd_0010b", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        txn("rd_0011", 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1);
        txn("rd_0200", 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1);
        txn("wr_0020", 1'b1, 16'h0020, 16'hA5A5, 16'h0000, 1'b0);
        txn("raw_0020", 1'b0, 16'h0020, 16'h0000, 16'hA5A5, 1'b0);

        // Backpressure: response must hold while further requests are ignored
        send(1'b0, 16'h0010, 16'h0000);
        get_rsp(lat, rd, er);
        chk("hold_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            req_write = 1'b1;
            req_addr  = 16'h0010;
            req_wdata = 16'hDEAD;
            req_valid = (i % 2) == 0;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, 16'hBEEF);
            chk("hold_err", rsp_err, 0);
            chk("hold_req_ready", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        finish_rsp("hold");
        txn("hold_rd", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // Reset during WAIT abandons the pending write
        txn("wr_0004", 1'b1, 16'h0004, 16'h0BAD, 16'h0000, 1'b0);
        send(1'b1, 16'h0004, 16'h1234);
        chk("abort_busy_wait", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 0);
        tick();
        chk("abort_rsp_valid2", rsp_valid, 0);
        tick();
        reset = 1'b1;
        tick();
        txn("abort_rd", 1'b0, 16'h0004, 16'h0000, 16'h0BAD, 1'b0);

        // Zero wait states, back-to-back with req_valid held high
        z_req_valid = 1'b1;
        z_req_write = 1'b1;
        z_req_addr  = 16'h0006;
        z_req_wdata = 16'h4242;
        chk("z_ready", z_req_ready, 1);
        tick();
        chk("z_wr_valid", z_rsp_valid, 1);
        chk("z_wr_err", z_rsp_err, 0);
        chk("z_wr_rdata", z_rsp_rdata, 0);
        chk("z_wr_ready", z_req_ready, 0);
        z_req_write = 1'b0;
        z_rsp_ready = 1'b1;
        tick();
        chk("z_hs_valid", z_rsp_valid, 0);
        chk("z_hs_ready", z_req_ready, 1);
        chk("z_hs_busy", z_busy, 0);
        tick();
        z_req_valid = 1'b0;
        chk("z_rd_valid", z_rsp_valid, 1);
        chk("z_rd_rdata", z_rsp_rdata, 16'h4242);
        chk("z_rd_err", z_rsp_err, 0);
        tick();
        z_rsp_ready = 1'b0;
        chk("z_rd_clr", z_rsp_valid, 0);
        chk("z_rd_clr_rdata", z_rsp_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
